// File: rtl/fb_arbiter.sv
// Framebuffer RAM arbiter: reserves every fourth visible pixel for a VGA read, shares the rest
// between two round-robin writers. Define FB_ARB_STATS_EN to add drop/stall counters.
module fb_arbiter #(
  parameter int unsigned FB_W   = 160,
  parameter int unsigned FB_H   = 120,
  parameter int unsigned ADDR_W = 15
) (
  input  logic              CLOCK_25,
  input  logic              reset,
  input  logic [9:0]        next_x,
  input  logic [9:0]        next_y,
  input  logic [1:0]        wr_valid,
  output logic [1:0]        wr_ready,
  input  logic [ADDR_W-1:0] wr_addr0,
  input  logic [ADDR_W-1:0] wr_addr1,
  input  logic [23:0]       wr_data0,
  input  logic [23:0]       wr_data1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [23:0]       mem_wdata,
  output logic              mem_we,
  input  logic [23:0]       mem_rdata,
`ifdef FB_ARB_STATS_EN
  output logic [15:0]       drop_cnt,
  output logic [15:0]       stall_cnt0,
  output logic [15:0]       stall_cnt1,
`endif
  output logic [7:0]        R_out,
  output logic [7:0]        G_out,
  output logic [7:0]        B_out
);

  localparam int unsigned FB_SIZE = FB_W * FB_H;

  logic              rd_slot;
  logic              rr;
  logic              rd_q1, rd_q2;
  logic              xfer;
  logic              sel;
  logic              in_range;
  logic [ADDR_W-1:0] sel_addr;
  logic [23:0]       sel_data;
  logic [ADDR_W-1:0] rd_addr;

  assign rd_slot = (next_x < 10'd640) && (next_y < 10'd480) && (next_x[1:0] == 2'b00);

  // Grant depends only on valid, rr and slot state, never on address or data.
  always_comb begin
    wr_ready = 2'b00;
    if (!reset && !rd_slot) begin
      if (wr_valid == 2'b11) wr_ready = rr ? 2'b10 : 2'b01;
      else                   wr_ready = wr_valid;
    end
  end

  assign xfer     = |(wr_valid & wr_ready);
  assign sel      = wr_ready[1];
  assign sel_addr = sel ? wr_addr1 : wr_addr0;
  assign sel_data = sel ? wr_data1 : wr_data0;
  assign in_range = 32'(sel_addr) < FB_SIZE;
  assign rd_addr  = ADDR_W'(32'(next_y[9:2]) * FB_W + 32'(next_x[9:2]));

  always_ff @(posedge CLOCK_25) begin
    if (reset) begin
      rr        <= 1'b0;
      rd_q1     <= 1'b0;
      rd_q2     <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      R_out     <= '0;
      G_out     <= '0;
      B_out     <= '0;
    end else begin
      // rd_q2 marks the cycle in which mem_rdata answers the read issued two cycles ago.
      rd_q1  <= rd_slot;
      rd_q2  <= rd_q1;
      mem_we <= 1'b0;
      if (rd_q2) {R_out, G_out, B_out} <= mem_rdata;
      if (rd_slot) begin
        mem_addr <= rd_addr;
      end else if (xfer) begin
        rr <= ~sel;
        if (in_range) begin
          mem_addr  <= sel_addr;
          mem_wdata <= sel_data;
          mem_we    <= 1'b1;
        end
      end
    end
  end

`ifdef FB_ARB_STATS_EN
  always_ff @(posedge CLOCK_25) begin
    if (reset) begin
      drop_cnt   <= '0;
      stall_cnt0 <= '0;
      stall_cnt1 <= '0;
    end else begin
      if (xfer && !in_range && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      if (wr_valid[0] && !wr_ready[0] && stall_cnt0 != 16'hFFFF) stall_cnt0 <= stall_cnt0 + 16'd1;
      if (wr_valid[1] && !wr_ready[1] && stall_cnt1 != 16'hFFFF) stall_cnt1 <= stall_cnt1 + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fb_arbiter.sv
// Bench for fb_arbiter: directed scenarios then randomized traffic against a reference model.
module tb_fb_arbiter;

  localparam int unsigned FB_W    = 160;
  localparam int unsigned FB_H    = 120;
  localparam int unsigned ADDR_W  = 15;
  localparam int unsigned FB_SIZE = FB_W * FB_H;

  logic              CLOCK_25;
  logic              reset;
  logic [9:0]        next_x, next_y;
  logic [1:0]        wr_valid, wr_ready;
  logic [ADDR_W-1:0] wr_addr0, wr_addr1, mem_addr;
  logic [23:0]       wr_data0, wr_data1, mem_wdata, mem_rdata;
  logic              mem_we;
  logic [7:0]        R_out, G_out, B_out;
`ifdef FB_ARB_STATS_EN
  logic [15:0]       drop_cnt, stall_cnt0, stall_cnt1;
`endif

  fb_arbiter #(.FB_W(FB_W), .FB_H(FB_H), .ADDR_W(ADDR_W)) dut (
    .CLOCK_25  (CLOCK_25),
    .reset     (reset),
    .next_x    (next_x),
    .next_y    (next_y),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr0  (wr_addr0),
    .wr_addr1  (wr_addr1),
    .wr_data0  (wr_data0),
    .wr_data1  (wr_data1),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata),
`ifdef FB_ARB_STATS_EN
    .drop_cnt  (drop_cnt),
    .stall_cnt0(stall_cnt0),
    .stall_cnt1(stall_cnt1),
`endif
    .R_out     (R_out),
    .G_out     (G_out),
    .B_out     (B_out)
  );

  initial CLOCK_25 = 1'b0;
  always #5 CLOCK_25 = ~CLOCK_25;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state
  int          m_rr;
  logic [23:0] m_colour;
  logic        m_we;
  int          m_addr;
  logic [23:0] m_wdata;
  int          load_q[$];
  int          cyc;
  int          m_drop;
  int          m_stall[2];
  logic [1:0]  obs_ready;

  task automatic model_reset();
    m_rr = 0; m_colour = '0; m_we = 0; m_addr = 0; m_wdata = '0;
    m_drop = 0; m_stall[0] = 0; m_stall[1] = 0;
    load_q.delete();
  endtask

  task automatic set_in(input int x, input int y, input int v, input int a0, input int d0,
                        input int a1, input int d1, input bit rst, input int rd);
    next_x = 10'(x); next_y = 10'(y); wr_valid = 2'(v);
    wr_addr0 = ADDR_W'(a0); wr_data0 = 24'(d0);
    wr_addr1 = ADDR_W'(a1); wr_data1 = 24'(d1);
    reset = rst; mem_rdata = 24'(rd);
  endtask

  // One clock: check grant mid-cycle, advance the model, check registered outputs after the edge.
  task automatic tick();
    bit         slot;
    logic [1:0] exp_ready;
    int         g;
    int         a;
    #4;
    slot = (next_x < 640) && (next_y < 480) && (next_x % 4 == 0);
    if (reset || slot)        exp_ready = 2'b00;
    else if (wr_valid == 2'b11) exp_ready = (m_rr == 0) ? 2'b01 : 2'b10;
    else                      exp_ready = wr_valid;
    obs_ready = wr_ready;
    check_eq("wr_ready", 32'(wr_ready), 32'(exp_ready));
    if (reset) begin
      model_reset();
    end else begin
      if (load_q.size() > 0 && load_q[0] == cyc) begin
        void'(load_q.pop_front());
        m_colour = mem_rdata;
      end
      for (int i = 0; i < 2; i++)
        if (wr_valid[i] && !exp_ready[i] && m_stall[i] < 65535) m_stall[i]++;
      m_we = 0;
      if (slot) begin
        m_addr = (int'(next_y) / 4) * FB_W + int'(next_x) / 4;
        load_q.push_back(cyc + 2);
      end else if (exp_ready != 2'b00) begin
        g = exp_ready[1] ? 1 : 0;
        a = g ? int'(wr_addr1) : int'(wr_addr0);
        if (a < FB_SIZE) begin
          m_we = 1; m_addr = a; m_wdata = g ? wr_data1 : wr_data0;
        end else if (m_drop < 65535) begin
          m_drop++;
        end
        m_rr = 1 - g;
      end
    end
    cyc++;
    @(posedge CLOCK_25);
    #1;
    check_eq("mem_we", 32'(mem_we), 32'(m_we));
    check_eq("mem_addr", 32'(mem_addr), 32'(m_addr));
    check_eq("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
    check_eq("colour", 32'({R_out, G_out, B_out}), 32'(m_colour));
`ifdef FB_ARB_STATS_EN
    check_eq("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    check_eq("stall_cnt0", 32'(stall_cnt0), 32'(m_stall[0]));
    check_eq("stall_cnt1", 32'(stall_cnt1), 32'(m_stall[1]));
`endif
  endtask

  initial begin
    int x, y, v, rst;
    cyc = 0;
    model_reset();
    set_in(0, 0, 0, 0, 0, 0, 0, 1'b1, 0);
    @(posedge CLOCK_25);
    #1;
    tick();
    tick();
    check_eq("rst_R", 32'(R_out), 32'h0);
    check_eq("rst_mem_addr", 32'(mem_addr), 32'h0);

    // Round-robin during blanking, writer 0 first
    set_in(0, 500, 3, 10, 'h111111, 20, 'h222222, 1'b0, 0);
    tick(); check_eq("rr_g0", 32'(obs_ready), 32'h1);
    tick(); check_eq("rr_g1", 32'(obs_ready), 32'h2);
    tick(); check_eq("rr_g2", 32'(obs_ready), 32'h1);

    // Out-of-range write accepted then dropped
    set_in(0, 500, 2, 0, 0, 19200, 'hABCDEF, 1'b0, 0);
    tick();
    check_eq("drop_ready", 32'(obs_ready), 32'h2);
    check_eq("drop_we", 32'(mem_we), 32'h0);
`ifdef FB_ARB_STATS_EN
    check_eq("drop_cnt1", 32'(drop_cnt), 32'h1);
`endif

    // Write in a non-read-slot visible cycle
    set_in(5, 0, 1, 100, 'hFF0000, 0, 0, 1'b0, 0);
    tick();
    check_eq("wr_we", 32'(mem_we), 32'h1);
    check_eq("wr_addr", 32'(mem_addr), 32'd100);
    check_eq("wr_data", 32'(mem_wdata), 32'hFF0000);

    // Read slot blocks writer
    set_in(4, 8, 1, 50, 'h010203, 0, 0, 1'b0, 0);
    tick();
    check_eq("rd_ready", 32'(obs_ready), 32'h0);
    check_eq("rd_addr", 32'(mem_addr), 32'd321);
    check_eq("rd_we", 32'(mem_we), 32'h0);

    // Drain, then colour latency of exactly 3 cycles
    set_in(0, 500, 0, 0, 0, 0, 0, 1'b0, 0);
    tick(); tick(); tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 1'b0, 'h123456);
    tick();
    next_x = 10'd1; tick();
    check_eq("lat_early", 32'({R_out, G_out, B_out}), 32'h0);
    next_x = 10'd2; tick();
    check_eq("lat_R", 32'(R_out), 32'h12);
    check_eq("lat_G", 32'(G_out), 32'h34);
    check_eq("lat_B", 32'(B_out), 32'h56);

    // Reset one cycle after a read slot discards it
    set_in(0, 0, 0, 0, 0, 0, 0, 1'b0, 'hFFFFFF);
    tick();
    set_in(1, 500, 3, 5, 1, 6, 2, 1'b1, 'hFFFFFF);
    tick();
    reset = 1'b0; wr_valid = 2'b00;
    tick(); tick();
    check_eq("rstrd_colour", 32'({R_out, G_out, B_out}), 32'h0);
    check_eq("rstrd_we", 32'(mem_we), 32'h0);
    wr_valid = 2'b11;
    tick();
    check_eq("rstrd_rr", 32'(obs_ready), 32'h1);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      x   = ($urandom_range(0, 9) < 7) ? $urandom_range(0, 639) : $urandom_range(640, 799);
      y   = ($urandom_range(0, 9) < 7) ? $urandom_range(0, 479) : $urandom_range(480, 524);
      v   = $urandom_range(0, 3);
      rst = ($urandom_range(0, 99) < 2) ? 1 : 0;
      set_in(x, y, v,
             ($urandom_range(0, 9) < 8) ? $urandom_range(0, FB_SIZE - 1) : $urandom_range(0, 32767),
             $urandom,
             ($urandom_range(0, 9) < 8) ? $urandom_range(0, FB_SIZE - 1) : $urandom_range(0, 32767),
             $urandom, rst[0], $urandom);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
